// File: rtl/iz_neuron_array.sv
// iz_neuron_array: one Izhikevich datapath time-shared over N neurons.
// Optional per-neuron spike counters: define IZ_ARRAY_SPIKE_CNT_EN.
module iz_neuron_array #(
  parameter int N        = 4,
  parameter int W        = 18,
  parameter int FRAC     = 8,
  parameter int DT_SHIFT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step,
  input  logic [8*N-1:0]       stim_in,
  input  logic                 load_en,
  input  logic                 load_data,
  input  logic [$clog2(N)-1:0] mon_sel,
  output logic                 busy,
  output logic                 done,
  output logic                 params_ready,
  output logic [N-1:0]         spike_vec,
  output logic [W-1:0]         mon_v,
  output logic [7:0]           mon_cnt
);
  localparam int IW = $clog2(N);
  localparam int XW = 2*W+8;
  localparam int BW = $clog2(4*W);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] UPDATE = 1'b1;

  localparam logic [IW-1:0] LAST    = IW'(N-1);
  localparam logic [BW-1:0] LASTBIT = BW'(4*W-1);

  localparam logic signed [W-1:0] V0 = W'(-65 * (2**FRAC));
  localparam logic signed [W-1:0] U0 = W'(-13 * (2**FRAC));
  localparam logic signed [W-1:0] A0 = W'(5);
  localparam logic signed [W-1:0] B0 = W'(51);
  localparam logic signed [W-1:0] C0 = W'(-16640);
  localparam logic signed [W-1:0] D0 = W'(2048);

  localparam logic signed [XW-1:0] K5   = XW'(5);
  localparam logic signed [XW-1:0] K41  = XW'(41);
  localparam logic signed [XW-1:0] K140 = XW'(140 * (2**FRAC));
  localparam logic signed [XW-1:0] VTH  = XW'(30 * (2**FRAC));
  localparam logic signed [XW-1:0] XMAX = XW'((2**(W-1)) - 1);
  localparam logic signed [XW-1:0] XMIN = XW'(-(2**(W-1)));

  function automatic logic signed [XW-1:0] sx(input logic signed [W-1:0] x);
    return {{(XW-W){x[W-1]}}, x};
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [XW-1:0] x);
    if (x > XMAX) return XMAX[W-1:0];
    if (x < XMIN) return XMIN[W-1:0];
    return x[W-1:0];
  endfunction

  logic [0:0]            r_state;
  logic [IW-1:0]         r_idx;
  logic signed [W-1:0]   r_v [N];
  logic signed [W-1:0]   r_u [N];
  logic signed [W-1:0]   r_a [N];
  logic signed [W-1:0]   r_b [N];
  logic signed [W-1:0]   r_c [N];
  logic signed [W-1:0]   r_d [N];
  logic                  r_done;
  logic                  r_pr;
  logic [N-1:0]          r_spk;
  logic [W-1:0]          r_mon_v;
  logic [4*W-2:0]        r_sh;
  logic [BW-1:0]         r_bit;
  logic [IW-1:0]         r_ptr;

  logic signed [7:0]     w_stim;
  logic signed [XW-1:0]  w_v, w_u, w_i, w_sq, w_q;
  logic signed [XW-1:0]  w_dv, w_bv, w_du;
  logic signed [W-1:0]   w_vn, w_un, w_ud, w_vw, w_uw;
  logic                  w_fire;
  logic [4*W-1:0]        w_word;

  always_comb begin
    w_v    = sx(r_v[r_idx]);
    w_u    = sx(r_u[r_idx]);
    w_stim = stim_in[8*r_idx +: 8];
    w_i    = {{(XW-8){w_stim[7]}}, w_stim} <<< FRAC;
    w_sq   = (w_v * w_v) >>> FRAC;
    w_q    = (w_sq * K41) >>> 10;
    w_dv   = (w_q + K5*w_v + K140 - w_u + w_i) >>> DT_SHIFT;
    w_bv   = (sx(r_b[r_idx]) * w_v) >>> FRAC;
    w_du   = ((sx(r_a[r_idx]) * (w_bv - w_u)) >>> FRAC) >>> DT_SHIFT;
    w_vn   = sat(w_v + w_dv);
    w_un   = sat(w_u + w_du);
    w_fire = sx(w_vn) >= VTH;
    w_ud   = sat(sx(w_un) + sx(r_d[r_idx]));
    w_vw   = w_fire ? r_c[r_idx] : w_vn;
    w_uw   = w_fire ? w_ud : w_un;
    w_word = {r_sh, load_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
      r_pr    <= 1'b1;
      r_spk   <= '0;
      r_mon_v <= V0;
      r_sh    <= '0;
      r_bit   <= '0;
      r_ptr   <= '0;
      for (int k = 0; k < N; k++) begin
        r_v[k] <= V0;
        r_u[k] <= U0;
        r_a[k] <= A0;
        r_b[k] <= B0;
        r_c[k] <= C0;
        r_d[k] <= D0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (step && !load_en && r_pr) begin
            r_state <= UPDATE;
            r_idx   <= '0;
          end
        end
        default: begin
          r_v[r_idx]   <= w_vw;
          r_u[r_idx]   <= w_uw;
          r_spk[r_idx] <= w_fire;
          if (r_idx == LAST) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
      endcase
      // Bits arriving during a sweep are dropped without touching the count.
      if (load_en && r_state == IDLE) begin
        if (r_pr) begin
          r_pr  <= 1'b0;
          r_ptr <= '0;
        end
        r_sh <= w_word[4*W-2:0];
        if (r_bit == LASTBIT) begin
          r_bit        <= '0;
          r_a[r_ptr]   <= w_word[4*W-1 -: W];
          r_b[r_ptr]   <= w_word[3*W-1 -: W];
          r_c[r_ptr]   <= w_word[2*W-1 -: W];
          r_d[r_ptr]   <= w_word[W-1 -: W];
          if (r_ptr == LAST) begin
            r_pr  <= 1'b1;
            r_ptr <= '0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end else begin
          r_bit <= r_bit + 1'b1;
        end
      end else if (!load_en) begin
        r_bit <= '0;
      end
      if (r_state == UPDATE && r_idx == mon_sel)
        r_mon_v <= w_vw;
      else
        r_mon_v <= r_v[mon_sel];
    end
  end

`ifdef IZ_ARRAY_SPIKE_CNT_EN
  logic [7:0] r_cnt [N];
  logic [7:0] r_mon_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mon_cnt <= '0;
      for (int k = 0; k < N; k++) r_cnt[k] <= '0;
    end else begin
      if (r_state == UPDATE && w_fire && r_cnt[r_idx] != 8'hFF)
        r_cnt[r_idx] <= r_cnt[r_idx] + 8'd1;
      if (r_state == UPDATE && r_idx == mon_sel && w_fire
          && r_cnt[r_idx] != 8'hFF)
        r_mon_cnt <= r_cnt[mon_sel] + 8'd1;
      else
        r_mon_cnt <= r_cnt[mon_sel];
    end
  end

  assign mon_cnt = r_mon_cnt;
`else
  assign mon_cnt = 8'd0;
`endif

  assign busy         = (r_state == UPDATE);
  assign done         = r_done;
  assign params_ready = r_pr;
  assign spike_vec    = r_spk;
  assign mon_v        = r_mon_v;

endmodule

// File: tb/tb_iz_neuron_array.sv
// Self-checking bench for iz_neuron_array against a behavioural model.
// Covers reset, sweep timing, resting, spiking, serial load, mid-sweep reset.
module tb_iz_neuron_array;
  localparam int N = 4;
  localparam int W = 18;
  localparam int FRAC = 8;
  localparam longint VMAX = 131071;
  localparam longint VMIN = -131072;

  logic             clk = 1'b0;
  logic             rst, step, load_en, load_data;
  logic [8*N-1:0]   stim_in;
  logic [1:0]       mon_sel;
  logic             busy, done, params_ready;
  logic [N-1:0]     spike_vec;
  logic [W-1:0]     mon_v;
  logic [7:0]       mon_cnt;

  iz_neuron_array dut (
    .clk(clk), .rst(rst), .step(step), .stim_in(stim_in),
    .load_en(load_en), .load_data(load_data), .mon_sel(mon_sel),
    .busy(busy), .done(done), .params_ready(params_ready),
    .spike_vec(spike_vec), .mon_v(mon_v), .mon_cnt(mon_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  longint mv[N], mu[N], ma[N], mb[N], mc[N], md[N];
  int     mcnt[N];
  bit     mspk[N];
  int     ms[N];

  typedef struct {
    logic [1:0] sel;
    longint     v;
    int         spk;
    int         pr;
    int         bsy;
    int         cnt;
  } rvec_t;
  rvec_t tbl[N];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, exp);
  endtask

  task automatic chk_ok(input string nm, input bit ok, input longint act);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, outside required bound", nm, act);
  endtask

  function automatic longint sat(input longint x);
    if (x > VMAX) return VMAX;
    if (x < VMIN) return VMIN;
    return x;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = -16640; mu[k] = -3328;
      ma[k] = 5; mb[k] = 51; mc[k] = -16640; md[k] = 2048;
      mcnt[k] = 0; mspk[k] = 0;
    end
  endfunction

  // Euler step of v' = 0.04v^2+5v+140-u+I, u' = a(bv-u) in Q.FRAC.
  function automatic void model_sweep();
    longint v, u, sq, q, i, dv, bv, du, vn, un;
    for (int k = 0; k < N; k++) begin
      v = mv[k]; u = mu[k];
      sq = (v * v) >>> FRAC;
      q  = (sq * 41) >>> 10;
      i  = longint'(ms[k]) * 256;
      dv = (q + 5*v + 140*256 - u + i) >>> 1;
      bv = (mb[k] * v) >>> FRAC;
      du = ((ma[k] * (bv - u)) >>> FRAC) >>> 1;
      vn = sat(v + dv);
      un = sat(u + du);
      if (vn >= 30*256) begin
        mv[k] = mc[k]; mu[k] = sat(un + md[k]); mspk[k] = 1;
        if (mcnt[k] < 255) mcnt[k]++;
      end else begin
        mv[k] = vn; mu[k] = un; mspk[k] = 0;
      end
    end
  endfunction

  task automatic apply_stim();
    for (int k = 0; k < N; k++) stim_in[8*k +: 8] = 8'(ms[k]);
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    model_reset();
  endtask

  task automatic do_sweep();
    bit got;
    apply_stim();
    step = 1'b1; cyc(); step = 1'b0;
    got = 0;
    for (int n = 0; n < N + 4 && !got; n++) begin
      cyc();
      if (done) got = 1;
    end
    chk("sweep_done", longint'(got), 1);
    model_sweep();
  endtask

  task automatic cmp();
    logic [N-1:0] es;
    int ec;
    for (int k = 0; k < N; k++) es[k] = mspk[k];
    chk("spike_vec", longint'(spike_vec), longint'(es));
    chk("mon_v", longint'($signed(mon_v)), mv[mon_sel]);
`ifdef IZ_ARRAY_SPIKE_CNT_EN
    ec = mcnt[mon_sel];
`else
    ec = 0;
`endif
    chk("mon_cnt", longint'(mon_cnt), longint'(ec));
  endtask

  task automatic load_bits(input logic [4*W-1:0] w, input int from, input int cnt);
    for (int i = from; i < from + cnt; i++) begin
      load_en = 1'b1;
      load_data = w[4*W-1-i];
      cyc();
    end
  endtask

  initial begin
    logic [4*W-1:0] wd[N];
    int bcnt, dcnt, dat, nspk;
    bit got;
    rst = 1'b1; step = 0; load_en = 0; load_data = 0;
    stim_in = '0; mon_sel = '0;
    for (int k = 0; k < N; k++) ms[k] = 0;

    // Reset state table
    for (int k = 0; k < N; k++)
      tbl[k] = '{sel: 2'(k), v: -16640, spk: 0, pr: 1, bsy: 0, cnt: 0};
    do_reset();
    for (int k = 0; k < N; k++) begin
      mon_sel = tbl[k].sel;
      cyc();
      chk("rst_mon_v", longint'($signed(mon_v)), tbl[k].v);
      chk("rst_spike", longint'(spike_vec), longint'(tbl[k].spk));
      chk("rst_pr", longint'(params_ready), longint'(tbl[k].pr));
      chk("rst_busy", longint'(busy), longint'(tbl[k].bsy));
      chk("rst_cnt", longint'(mon_cnt), longint'(tbl[k].cnt));
    end

    // Sweep timing with an ignored step at t+2
    mon_sel = 2'd0;
    bcnt = 0; dcnt = 0; dat = -1;
    step = 1'b1;
    for (int k = 1; k <= N + 3; k++) begin
      cyc();
      step = (k == 2);
      if (busy) bcnt++;
      if (done) begin dcnt++; dat = k; end
    end
    step = 1'b0;
    model_sweep();
    chk("busy_cycles", bcnt, N);
    chk("done_pulses", dcnt, 1);
    chk("done_at", dat, N + 1);
    cmp();

    // Randomised stimulus
    for (int s = 0; s < 150; s++) begin
      for (int k = 0; k < N; k++) ms[k] = int'($urandom_range(35)) - 10;
      mon_sel = 2'($urandom_range(N - 1));
      do_sweep();
      cmp();
    end

    // Resting stability
    do_reset();
    for (int k = 0; k < N; k++) ms[k] = 0;
    for (int s = 0; s < 1000; s++) begin
      mon_sel = 2'(s % N);
      do_sweep();
      cmp();
      chk("rest_nospike", longint'(spike_vec), 0);
      chk_ok("rest_range", $signed(mon_v) >= -72*256 && $signed(mon_v) <= -60*256,
             longint'($signed(mon_v)));
    end

    // Spiking selectivity
    do_reset();
    ms[0] = 10;
    mon_sel = 2'd0;
    nspk = 0;
    for (int s = 0; s < 500; s++) begin
      do_sweep();
      cmp();
      chk("quiet_others", longint'(spike_vec[N-1:1]), 0);
      if (spike_vec[0]) begin
        nspk++;
        chk("post_spike_v0", longint'($signed(mon_v)), -16640);
      end
    end
    chk_ok("n0_spikes", nspk > 1, nspk);
`ifdef IZ_ARRAY_SPIKE_CNT_EN
    chk_ok("n0_cnt", mon_cnt > 0, longint'(mon_cnt));
`endif

    // Serial load with a dropped partial word
    mc[2] = -12800; md[2] = 512;
    for (int k = 0; k < N; k++)
      wd[k] = {W'(ma[k]), W'(mb[k]), W'(mc[k]), W'(md[k])};
    load_bits(wd[0], 0, 4*W);
    chk("pr_low_w0", longint'(params_ready), 0);
    load_bits(wd[1], 0, 30);
    load_en = 1'b0; cyc();
    chk("pr_low_drop", longint'(params_ready), 0);
    step = 1'b1; cyc(); step = 1'b0; cyc();
    chk("step_blocked", longint'(busy), 0);
    load_bits(wd[1], 0, 4*W);
    load_bits(wd[2], 0, 4*W);
    load_bits(wd[3], 0, 4*W - 1);
    chk("pr_low_287", longint'(params_ready), 0);
    load_bits(wd[3], 4*W - 1, 1);
    load_en = 1'b0;
    chk("pr_high_288", longint'(params_ready), 1);
    cyc();

    for (int k = 0; k < N; k++) ms[k] = 0;
    ms[2] = 10;
    mon_sel = 2'd2;
    nspk = 0;
    for (int s = 0; s < 300; s++) begin
      do_sweep();
      cmp();
      if (mspk[2]) begin
        nspk++;
        chk("post_spike_v2", longint'($signed(mon_v)), -12800);
      end
    end
    chk_ok("n2_spikes", nspk > 0, nspk);

    // load_en during a sweep is ignored
    apply_stim();
    step = 1'b1; cyc(); step = 1'b0;
    got = 0;
    for (int n = 0; n < N; n++) begin
      load_en = 1'b1; load_data = 1'b1;
      cyc();
      if (done) got = 1;
    end
    load_en = 1'b0;
    model_sweep();
    chk("busy_load_done", longint'(got), 1);
    chk("busy_load_pr", longint'(params_ready), 1);
    cmp();

    // Reset in the second busy cycle
    for (int k = 0; k < N; k++) ms[k] = int'($urandom_range(20));
    apply_stim();
    step = 1'b1; cyc(); step = 1'b0;
    cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    model_reset();
    chk("mid_rst_busy", longint'(busy), 0);
    dcnt = 0;
    for (int n = 0; n < N + 3; n++) begin
      if (done) dcnt++;
      cyc();
    end
    chk("mid_rst_nodone", dcnt, 0);
    for (int k = 0; k < N; k++) begin
      mon_sel = 2'(k);
      cyc();
      chk("mid_rst_v", longint'($signed(mon_v)), -16640);
    end
    chk("mid_rst_spike", longint'(spike_vec), 0);
    do_sweep();
    cmp();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/iz_neuron_array.md
Name: iz_neuron_array

Overview:
- Parametrised successor to the single Izhikevich neuron core.
- Time-multiplexes one fixed-point Izhikevich datapath over N neurons, each with its own state (v, u) and its own parameter set (a, b, c, d).
- Parameters are loaded over a serial shift port; membrane potential, spike flags and a monitor view are provided for the Tiny Tapeout top-level wrapper.

Parameters:
- N, 4, number of neurons (2..16).
- W, 18, signed word width of v, u, a, b, c, d.
- FRAC, 8, fractional bits of all fixed-point quantities.
- DT_SHIFT, 1, Euler step = 2^-DT_SHIFT ms.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- step  in  1  one-cycle pulse that starts one update sweep over all neurons.
- stim_in  in  8*N  signed 8-bit input current per neuron; neuron k uses bits [8k+7:8k].
- load_en  in  1  serial parameter load enable.
- load_data  in  1  serial parameter bit, MSB first.
- mon_sel  in  clog2(N)  neuron selected for the monitor outputs.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- params_ready  out  1  all N parameter sets are valid.
- spike_vec  out  N  per-neuron spike flag from that neuron's last update.
- mon_v  out  W  v of neuron mon_sel, registered.
- mon_cnt  out  8  spike count of neuron mon_sel (optional feature).

Behaviour:
- Reset, applied on any clk edge with rst=1 (including mid-sweep or mid-load):
  - all neurons: v=-65<<FRAC, u=-13<<FRAC;
  - params = regular spiking: a=5, b=51, c=-16640, d=2048 (FRAC=8 encodings);
  - busy=0, done=0, spike_vec=0, mon_v=-16640, mon_cnt=0, params_ready=1;
  - load shift register and load pointer cleared.
- FSM states IDLE, UPDATE:
  - IDLE->UPDATE when step=1, load_en=0 and params_ready=1; otherwise step is ignored. idx=0, busy=1 from the next cycle.
  - UPDATE processes neuron idx in one cycle and writes back v, u and spike_vec[idx]; idx increments.
  - After idx=N-1: UPDATE->IDLE, busy=0, done=1 for one cycle.
  - step during UPDATE is ignored.
  - Latency: step at cycle t gives busy=1 for t+1..t+N and done at t+N+1.
- Arithmetic, all intermediates 2W+8 bits signed, arithmetic shifts:
  - sq = (v*v)>>>FRAC
  - q = (sq*41)>>>10
  - I = sign-extended stim<<FRAC
  - dv = (q + 5v + (140<<FRAC) - u + I)>>>DT_SHIFT
  - du = ((a*(((b*v)>>>FRAC) - u))>>>FRAC)>>>DT_SHIFT
  - vn = sat_W(v+dv), un = sat_W(u+du); sat_W clamps to the W-bit signed range.
- Spike rule:
  - if vn >= 30<<FRAC: v<=c, u<=sat_W(un+d), spike_vec[idx]=1;
  - else v<=vn, u<=un, spike_vec[idx]=0.
- mon_v: registered every cycle from v[mon_sel], one cycle latency; it reflects the write-back of the same cycle.
- Serial load, active only while load_en=1 and busy=0:
  - one bit shifted per clk into a 4W-bit register, field order a, b, c, d, MSB first;
  - first load_en bit after params_ready=1 clears params_ready and sets ptr=0;
  - every 4W bits, the word commits to neuron ptr and ptr++;
  - after neuron N-1 commits: params_ready=1, ptr=0.
- Load boundary cases:
  - load_en falling mid-word discards the partial bits and resets the bit counter; ptr and committed sets are kept; params_ready stays 0 until N sets are committed.
  - load_en=1 while busy: bits are dropped and the counter is unchanged.
- Loading never alters v or u.

Optional Feature:
- Macro IZ_ARRAY_SPIKE_CNT_EN.
- Defined:
  - each neuron has an 8-bit counter, incremented on each spike and saturating at 255;
  - all counters clear on reset;
  - mon_cnt is the registered count of neuron mon_sel, one cycle latency.
- Undefined: no counters; mon_cnt is constant 0.

Test Plan:
- Reset check: assert rst for 2 cycles, then mon_sel=0..N-1. Expect mon_v=-16640 for each, spike_vec=0, params_ready=1, busy=0, mon_cnt=0.
- Sweep timing: step pulse at cycle t. Expect busy high for exactly N=4 cycles, done single pulse at t+5; a step at t+2 has no effect.
- Resting stability: stim=0 on all neurons, 1000 steps. Expect no spike on any neuron and mon_v within [-72,-60]<<FRAC.
- Spiking selectivity: stim neuron0=10, others=0, 500 steps.
  - Neuron 0 spikes repeatedly: after its spike sweep, mon_v equals c=-16640.
  - mon_cnt(0) > 0 with the feature defined.
  - Neurons 1..3 never spike.
- Serial load: shift 4 sets of 4*18 bits with neuron2 c=-12800 and d=512. Expect params_ready low during the load and high after bit 288. With stim2=10, neuron 2's post-spike mon_v=-12800. A load_en drop after 30 bits leaves ptr unchanged.
- Reset mid-sweep: rst at the 2nd busy cycle. Next cycle: busy=0, done never pulses, all v=-16640, step accepted again afterwards.
